// File: rtl/kmac_app_arbiter.sv
// Round-robin arbiter sharing one KMAC application port between NumReq requesters.
// The grant is held for a whole message; it also handles aborts and a hung-KMAC watchdog.
module kmac_app_arbiter #(
  parameter int NumReq        = 3,
  parameter int DataWidth     = 64,
  parameter int DigestWidth   = 256,
  parameter int TimeoutCycles = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq-1:0]               req_active_i,
  input  logic [NumReq-1:0]               req_valid_i,
  input  logic [NumReq*DataWidth-1:0]     req_data_i,
  input  logic [NumReq*(DataWidth/8)-1:0] req_strb_i,
  input  logic [NumReq-1:0]               req_last_i,
  output logic [NumReq-1:0]               req_ready_o,
  output logic [NumReq-1:0]               req_done_o,
  output logic [NumReq-1:0]               req_error_o,
  output logic [2*DigestWidth-1:0]        digest_o,
  output logic                            kmac_valid_o,
  output logic [DataWidth-1:0]            kmac_data_o,
  output logic [DataWidth/8-1:0]          kmac_strb_o,
  output logic                            kmac_last_o,
  input  logic                            kmac_ready_i,
  input  logic                            kmac_done_i,
  input  logic                            kmac_error_i,
  input  logic [2*DigestWidth-1:0]        kmac_digest_i,
  output logic                            busy_o,
  output logic                            fsm_error_o
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int WdW       = $clog2(TimeoutCycles) + 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);
  localparam logic [WdW-1:0]  WdLimit = WdW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StTx    = 3'd1,
    StWait  = 3'd2,
    StDone  = 3'd3,
    StError = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d, gnt_q, gnt_d;
  logic [WdW-1:0]  wdog_q, wdog_d;
  logic            abort_q, abort_d, err_q, err_d;

  logic                 found;
  logic [IdxW-1:0]      winner, cand;
  logic                 act_g, valid_g, last_g, tx_valid, tx_last;
  logic [DataWidth-1:0] data_g;
  logic [StrbWidth-1:0] strb_g;

  // First active requester at or after the rr pointer, wrapping
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = IdxW'((int'(rr_q) + i) % NumReq);
      if (!found && req_active_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    act_g   = 1'b0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    data_g  = '0;
    strb_g  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (gnt_q == IdxW'(i)) begin
        act_g   = req_active_i[i];
        valid_g = req_valid_i[i];
        last_g  = req_last_i[i];
        data_g  = req_data_i[i*DataWidth +: DataWidth];
        strb_g  = req_strb_i[i*StrbWidth +: StrbWidth];
      end
    end
  end

  // After an abort the arbiter itself closes the message with an empty last beat
  assign tx_valid = abort_q | valid_g;
  assign tx_last  = abort_q | last_g;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rr_q    <= '0;
      gnt_q   <= '0;
      wdog_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      wdog_q  <= wdog_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    wdog_d  = wdog_q;
    abort_d = abort_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          gnt_d   = winner;
          rr_d    = (winner == LastIdx) ? '0 : winner + 1'b1;
          state_d = StTx;
        end
      end
      StTx: begin
        if (!act_g) abort_d = 1'b1;
        if (tx_valid && tx_last && kmac_ready_i) begin
          state_d = StWait;
          wdog_d  = '0;
        end
      end
      StWait: begin
        if (!act_g) abort_d = 1'b1;
        wdog_d = wdog_q + 1'b1;
        // A done on the expiry cycle still wins over the timeout
        if (kmac_done_i) begin
          err_d   = kmac_error_i | abort_q | ~act_g;
          state_d = StDone;
        end else if (wdog_q == WdLimit) begin
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (!act_g) begin
          state_d = StIdle;
          abort_d = 1'b0;
          err_d   = 1'b0;
          wdog_d  = '0;
        end
      end
      StError: state_d = StError;
      default: state_d = StError;
    endcase
  end

  always_comb begin
    req_ready_o  = '0;
    req_done_o   = '0;
    req_error_o  = '0;
    digest_o     = '0;
    kmac_valid_o = 1'b0;
    kmac_data_o  = '0;
    kmac_strb_o  = '0;
    kmac_last_o  = 1'b0;
    busy_o       = (state_q != StIdle);
    fsm_error_o  = 1'b0;
    case (state_q)
      StIdle, StWait: ;
      StTx: begin
        kmac_valid_o = tx_valid;
        kmac_last_o  = tx_last;
        kmac_data_o  = abort_q ? '0 : data_g;
        kmac_strb_o  = abort_q ? '0 : strb_g;
        for (int i = 0; i < NumReq; i++) begin
          if (gnt_q == IdxW'(i)) req_ready_o[i] = kmac_ready_i & ~abort_q;
        end
      end
      StDone: begin
        if (!abort_q) begin
          for (int i = 0; i < NumReq; i++) begin
            if (gnt_q == IdxW'(i)) begin
              req_done_o[i]  = 1'b1;
              req_error_o[i] = err_q;
            end
          end
          if (!err_q) digest_o = kmac_digest_i;
        end
      end
      default: begin
        req_done_o  = '1;
        req_error_o = '1;
        fsm_error_o = 1'b1;
      end
    endcase
  end

endmodule
